// File: rtl/si570_pkg.sv
// Shared constants, state encoding and field-legality helper for the Si-570 frequency decoder.
package si570_pkg;

  localparam int FB      = 28;
  localparam int RFREQ_W = 38;
  localparam int FXTAL_W = 32;
  localparam int P_W     = FXTAL_W + RFREQ_W;
  localparam int DIV_W   = 13;
  localparam int REM_W   = DIV_W + 1;
  localparam int FDCO_W  = 36;
  localparam int CNT_W   = 7;

  localparam logic [FDCO_W-1:0] DCO_MIN_HZ = 36'd4_850_000_000;
  localparam logic [FDCO_W-1:0] DCO_MAX_HZ = 36'd5_670_000_000;

  // Bit n set means HS_DIV register value n is a legal encoding.
  localparam logic [7:0] HS_DIV_LEGAL = 8'b1010_1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MUL,
    S_DIV,
    S_FINISH
  } state_e;

  // N1 = reg+1 must be 1 or even, so the register must be 0 or odd.
  function automatic logic n1Legal(input logic [6:0] n1Reg);
    return (n1Reg == 7'd0) || n1Reg[0];
  endfunction

endpackage

// File: rtl/si570_seq_mul.sv
// Generic sequential shift-add multiplier: one B bit per cycle, LSB first, fixed latency of B_W cycles.
module si570_seq_mul #(
  parameter int A_W = 32,
  parameter int B_W = 38
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  output logic               done_o,
  output logic [A_W+B_W-1:0] p_o
);

  localparam int P_W   = A_W + B_W;
  localparam int MCNT_W = $clog2(B_W + 1);

  logic [P_W-1:0]    aSh_q;
  logic [P_W-1:0]    acc_q;
  logic [P_W-1:0]    acc_d;
  logic [B_W-1:0]    b_q;
  logic [MCNT_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;

  assign acc_d  = b_q[0] ? (acc_q + aSh_q) : acc_q;
  assign done_o = done_q;
  assign p_o    = acc_q;

  // A new start always restarts the operation, even if a previous one is still running.
  always_ff @(posedge clk) begin
    if (reset) begin
      aSh_q  <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      aSh_q  <= P_W'(a_i);
      acc_q  <= '0;
      b_q    <= b_i;
      cnt_q  <= MCNT_W'(B_W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      acc_q  <= acc_d;
      aSh_q  <= aSh_q << 1;
      b_q    <= b_q >> 1;
      cnt_q  <= cnt_q - MCNT_W'(1);
      busy_q <= (cnt_q != MCNT_W'(1));
      done_q <= (cnt_q == MCNT_W'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

endmodule

// File: rtl/si570_freq_decode.sv
// Si-570 register readback: fout = fxtal * RFREQ / (HS_DIV * N1), rounded half-up and saturated.
// Define SI570_DCO_CHECK_EN to build the DCO range comparators behind dco_err.
module si570_freq_decode
  import si570_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [47:0]       si570_regs,
  input  logic [31:0]       fxtal,
  input  logic              start,
  output logic              idle,
  output logic              done,
  output logic [OUT_W-1:0]  fout,
  output logic [FDCO_W-1:0] fdco,
  output logic              cfg_err,
  output logic              ovf,
  output logic              dco_err
);

  localparam int R_W = P_W - FB + 1;

  state_e              state_q;
  logic [2:0]          hsReg_q;
  logic [6:0]          n1Reg_q;
  logic [DIV_W-1:0]    divisor_q;
  logic [P_W-1:0]      quot_q;
  logic [REM_W-1:0]    rem_q;
  logic [CNT_W-1:0]    divCnt_q;
  logic [FDCO_W-1:0]   fdcoHold_q;
  logic                cfgBad_q;
  logic                done_q;
  logic [OUT_W-1:0]    fout_q;
  logic [FDCO_W-1:0]   fdco_q;
  logic                cfgErr_q;
  logic                ovf_q;
  logic                dcoErr_q;

  logic                mulStart;
  logic                mulDone;
  logic [P_W-1:0]      mulProd;

  logic [3:0]          hsDiv;
  logic [7:0]          n1;
  logic [DIV_W-1:0]    divxn1;
  logic                cfgOk;

  logic [REM_W-1:0]    remShift;
  logic                remFits;
  logic [REM_W-1:0]    rem_d;
  logic [P_W-1:0]      quot_d;

  logic [R_W-1:0]      rounded;
  logic                ovf_d;
  logic [OUT_W-1:0]    fout_d;
  logic                dcoErr_d;

  assign idle     = (state_q == S_IDLE) && !start;
  assign mulStart = start && (state_q == S_IDLE);

  assign done    = done_q;
  assign fout    = fout_q;
  assign fdco    = fdco_q;
  assign cfg_err = cfgErr_q;
  assign ovf     = ovf_q;
  assign dco_err = dcoErr_q;

  // The multiplier captures fxtal and RFREQ itself on the accepting edge and overlaps the decode cycle.
  si570_seq_mul #(
    .A_W (FXTAL_W),
    .B_W (RFREQ_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (mulStart),
    .a_i     (fxtal),
    .b_i     (si570_regs[RFREQ_W-1:0]),
    .done_o  (mulDone),
    .p_o     (mulProd)
  );

  assign hsDiv  = {1'b0, hsReg_q} + 4'd4;
  assign n1     = {1'b0, n1Reg_q} + 8'd1;
  assign divxn1 = DIV_W'(hsDiv) * DIV_W'(n1);
  assign cfgOk  = HS_DIV_LEGAL[hsReg_q] && n1Legal(n1Reg_q);

  // Restoring division step: the remainder stays below the divisor, so 14 bits always suffice.
  assign remShift = {rem_q[REM_W-2:0], quot_q[P_W-1]};
  assign remFits  = (remShift >= {1'b0, divisor_q});
  assign rem_d    = remFits ? (remShift - {1'b0, divisor_q}) : remShift;
  assign quot_d   = {quot_q[P_W-2:0], remFits};

  assign rounded = {1'b0, quot_q[P_W-1:FB]} + R_W'(quot_q[FB-1]);
  assign ovf_d   = |rounded[R_W-1:OUT_W];
  assign fout_d  = ovf_d ? '1 : rounded[OUT_W-1:0];

`ifdef SI570_DCO_CHECK_EN
  logic pHigh_q;
  assign dcoErr_d = pHigh_q || (fdcoHold_q < DCO_MIN_HZ) || (fdcoHold_q > DCO_MAX_HZ);
`else
  assign dcoErr_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hsReg_q    <= '0;
      n1Reg_q    <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divCnt_q   <= '0;
      fdcoHold_q <= '0;
      cfgBad_q   <= 1'b0;
      done_q     <= 1'b0;
      fout_q     <= '0;
      fdco_q     <= '0;
      cfgErr_q   <= 1'b0;
      ovf_q      <= 1'b0;
      dcoErr_q   <= 1'b0;
`ifdef SI570_DCO_CHECK_EN
      pHigh_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            hsReg_q <= si570_regs[47:45];
            n1Reg_q <= si570_regs[44:38];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (cfgOk) begin
            cfgBad_q  <= 1'b0;
            divisor_q <= divxn1;
            state_q   <= S_MUL;
          end else begin
            cfgBad_q <= 1'b1;
            cfgErr_q <= 1'b1;
            fout_q   <= '0;
            fdco_q   <= '0;
            ovf_q    <= 1'b0;
            dcoErr_q <= 1'b0;
            state_q  <= S_FINISH;
          end
        end
        S_MUL: begin
          if (mulDone) begin
            quot_q     <= mulProd;
            rem_q      <= '0;
            divCnt_q   <= CNT_W'(P_W - 1);
            fdcoHold_q <= mulProd[FB+FDCO_W-1:FB];
`ifdef SI570_DCO_CHECK_EN
            pHigh_q    <= |mulProd[P_W-1:FB+FDCO_W];
`endif
            state_q    <= S_DIV;
          end
        end
        S_DIV: begin
          quot_q   <= quot_d;
          rem_q    <= rem_d;
          divCnt_q <= divCnt_q - CNT_W'(1);
          if (divCnt_q == '0) state_q <= S_FINISH;
        end
        S_FINISH: begin
          if (!cfgBad_q) begin
            fout_q   <= fout_d;
            ovf_q    <= ovf_d;
            fdco_q   <= fdcoHold_q;
            dcoErr_q <= dcoErr_d;
            cfgErr_q <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_si570_freq_decode.sv
// Directed self-checking bench for si570_freq_decode; honours SI570_DCO_CHECK_EN for dco_err.
module tb_si570_freq_decode;

`ifdef SI570_DCO_CHECK_EN
  localparam logic DCO_EN = 1'b1;
`else
  localparam logic DCO_EN = 1'b0;
`endif

  localparam logic [37:0] RF_50  = 38'h3_2000_0000;
  localparam logic [37:0] RF_1   = 38'h0_1000_0000;
  localparam logic [37:0] RF_MAX = 38'h3F_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] si570Regs = '0;
  logic [31:0] fxtal = '0;
  logic        start = 1'b0;
  logic        idle;
  logic        done;
  logic [31:0] fout;
  logic [35:0] fdco;
  logic        cfgErr;
  logic        ovf;
  logic        dcoErr;

  int compared = 0;
  int mismatched = 0;

  si570_freq_decode dut (
    .clk        (clk),
    .reset      (reset),
    .si570_regs (si570Regs),
    .fxtal      (fxtal),
    .start      (start),
    .idle       (idle),
    .done       (done),
    .fout       (fout),
    .fdco       (fdco),
    .cfg_err    (cfgErr),
    .ovf        (ovf),
    .dco_err    (dcoErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request, scrambles the inputs afterwards, and returns the cycle index of done (E0 = 1).
  task automatic applyStimulus(input logic [47:0] regs, input logic [31:0] fx, output int cycles);
    @(negedge clk);
    si570Regs = regs;
    fxtal     = fx;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    si570Regs = ~regs;
    fxtal     = ~fx;
    cycles    = 1;
    while (!done && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) checkOutput("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic checkResult(input string tag, input logic [31:0] expFout, input logic [35:0] expFdco,
                             input logic expCfg, input logic expOvf, input logic expDco);
    checkOutput({tag, "_fout"}, 64'(fout), 64'(expFout));
    checkOutput({tag, "_fdco"}, 64'(fdco), 64'(expFdco));
    checkOutput({tag, "_cfg_err"}, 64'(cfgErr), 64'(expCfg));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(expOvf));
    checkOutput({tag, "_dco_err"}, 64'(dcoErr), 64'(expDco));
  endtask

  initial begin
    int cycles;
    int doneCnt;
    int doneAt;
    logic [31:0] foutSeen;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_idle", 64'(idle), 64'(1));
    checkResult("rst", 32'd0, 36'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus({3'd1, 7'd1, RF_50}, 32'd100_000_000, cycles);
    checkOutput("nom_latency", 64'(cycles), 64'(111));
    checkResult("nom", 32'd500_000_000, 36'd5_000_000_000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("nom_done_strobe", 64'(done), 64'(0));
    checkOutput("nom_hold", 64'(fout), 64'(500_000_000));

    applyStimulus({3'd0, 7'd0, RF_1}, 32'd10, cycles);
    checkResult("round", 32'd3, 36'd10, 1'b0, 1'b0, DCO_EN);

    applyStimulus({3'd4, 7'd1, RF_50}, 32'd100_000_000, cycles);
    checkOutput("hs_ill_latency", 64'(cycles), 64'(3));
    checkResult("hs_ill", 32'd0, 36'd0, 1'b1, 1'b0, 1'b0);

    // Back-to-back: the next request is raised in the done cycle of the previous one.
    applyStimulus({3'd1, 7'd2, RF_50}, 32'd100_000_000, cycles);
    checkOutput("n1_ill_latency", 64'(cycles), 64'(3));
    checkResult("n1_ill", 32'd0, 36'd0, 1'b1, 1'b0, 1'b0);

    applyStimulus({3'd5, 7'd0, RF_50}, 32'd100_000_000, cycles);
    checkResult("div9", 32'd555_555_556, 36'd5_000_000_000, 1'b0, 1'b0, 1'b0);

    applyStimulus({3'd7, 7'd127, RF_50}, 32'd100_000_000, cycles);
    checkResult("div1408", 32'd3_551_136, 36'd5_000_000_000, 1'b0, 1'b0, 1'b0);

    applyStimulus({3'd0, 7'd0, RF_MAX}, 32'hFFFF_FFFF, cycles);
    checkResult("ovf", 32'hFFFF_FFFF, 36'hF_FFFF_FBF0, 1'b0, 1'b1, DCO_EN);

    applyStimulus({3'd1, 7'd1, RF_50}, 32'd0, cycles);
    checkResult("zero", 32'd0, 36'd0, 1'b0, 1'b0, DCO_EN);

    // Busy start: a second request at cycle 40 must be dropped.
    @(negedge clk);
    si570Regs = {3'd1, 7'd1, RF_50};
    fxtal     = 32'd100_000_000;
    start     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busy_idle_low", 64'(idle), 64'(0));
    doneCnt = 0;
    doneAt  = 0;
    foutSeen = '0;
    for (int c = 2; c <= 160; c++) begin
      @(negedge clk);
      start = (c == 40);
      if (c == 40) begin
        si570Regs = {3'd0, 7'd0, RF_1};
        fxtal     = 32'd10;
      end
      @(posedge clk);
      #1;
      if (done) begin
        doneCnt++;
        doneAt   = c;
        foutSeen = fout;
      end
    end
    checkOutput("busy_done_count", 64'(doneCnt), 64'(1));
    checkOutput("busy_done_at", 64'(doneAt), 64'(111));
    checkOutput("busy_fout", 64'(foutSeen), 64'(500_000_000));
    checkOutput("busy_idle_end", 64'(idle), 64'(1));

    // Reset at cycle 60 of a nominal request.
    @(negedge clk);
    si570Regs = {3'd1, 7'd1, RF_50};
    fxtal     = 32'd100_000_000;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    doneCnt = 0;
    for (int c = 2; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (done) doneCnt++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    if (done) doneCnt++;
    checkOutput("rstmid_idle", 64'(idle), 64'(1));
    checkResult("rstmid", 32'd0, 36'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk);
      #1;
      if (done) doneCnt++;
    end
    checkOutput("rstmid_no_done", 64'(doneCnt), 64'(0));
    checkOutput("rstmid_fout_held", 64'(fout), 64'(0));

    applyStimulus({3'd1, 7'd1, RF_50}, 32'd100_000_000, cycles);
    checkOutput("post_rst_latency", 64'(cycles), 64'(111));
    checkResult("post_rst", 32'd500_000_000, 36'd5_000_000_000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
